sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  frame-start pulse; opens a new word.
REQ-005 bit_valid  input  1  qualifies serial_in this cycle.
REQ-006 serial_in  input  1  serial data bit, first bit = word MSB.
REQ-007 cont  input  1  level; high = stay in SHIFT after each word (continuous framing).
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 clear_err  input  1  clears sticky overrun.
REQ-010 out_data  output  WIDTH  completed word.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 busy  output  1  high while in SHIFT.
REQ-013 bit_cnt  output  $clog2(WIDTH)  bits accepted in current word.
REQ-014 overrun  output  1  sticky; a completed word was dropped.

Function
REQ-015 FSM states SHALL be IDLE and SHIFT; busy = (state == SHIFT).
REQ-016 IDLE: start -> SHIFT, bit_cnt and shifter cleared; bit_valid in the same cycle is ignored; bit_valid without start is ignored.
REQ-017 SHIFT: each bit_valid cycle SHALL shift the shifter left, insert serial_in at LSB, and increment bit_cnt.
REQ-018 Word completes on the bit_valid cycle with bit_cnt == WIDTH-1; bit_cnt returns to 0.
REQ-019 On completion: cont low -> IDLE; cont high -> remain in SHIFT for the next word.
REQ-020 start in SHIFT SHALL restart: partial word discarded, bit_cnt = 0, shifter cleared, remain in SHIFT; a coincident bit_valid is ignored (start has priority).
REQ-021 Output buffer is one word deep; on completion the word loads into out_data if out_valid is low, or if out_valid and out_ready are both high that cycle.
REQ-022 Latency: out_valid SHALL rise the cycle after the completing bit, with out_data = {first bit, ..., last bit}.
REQ-023 out_valid SHALL stay high and out_data stable until the cycle after out_valid && out_ready.
REQ-024 If completion occurs with out_valid high and out_ready low, the new word SHALL be dropped, the held word kept, and overrun set the next cycle.
REQ-025 overrun clears on clear_err; a simultaneous new overrun event takes priority (overrun stays 1).
REQ-026 out_ready while out_valid is low has no effect.

Reset
REQ-027 reset SHALL force state IDLE, shifter 0, bit_cnt 0, out_data 0, out_valid 0, overrun 0, busy 0, overriding all other inputs that cycle.
REQ-028 reset mid-word or with out_valid high SHALL discard all data; no word is presented afterward.

Structure
REQ-029 The state encodings (IDLE = 0, SHIFT = 1) SHALL live in the shared package sipo_ctrl_pkg.
REQ-030 The shifter SHALL be a sub-module sipo_shift_core (WIDTH, clk, reset, clr, shift_en, serial_in, q), a left-shifting register with LSB insert.
REQ-031 The FSM, bit counter, output buffer and overrun flag SHALL reside in sipo_frame_ctrl.

Verification (WIDTH = 8)
REQ-032 Basic frame: start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready = 1 -> out_valid for 1 cycle with out_data = 0xB2, then IDLE, busy = 0.
REQ-033 Gapped bits: same bits with bit_valid low every other cycle -> out_data = 0xB2; bit_cnt advances only on bit_valid cycles.
REQ-034 Backpressure/overrun: cont = 1, out_ready = 0, send 0xB2 then 0x5A -> out_data holds 0xB2, overrun = 1; then out_ready = 1 -> 0xB2 consumed; clear_err -> overrun = 0.
REQ-035 Back-to-back accept: cont = 1, out_ready pulsed in the completion cycle of word 2 -> out_data changes 0xB2 -> 0x5A with out_valid held high, no overrun.
REQ-036 Restart: start, 5 bits, start again, then bits of 0x3C -> out_data = 0x3C; the partial bits never appear.
REQ-037 Reset mid-word: after 4 bits assert reset for 1 cycle -> all outputs 0, IDLE; 8 further bit_valid cycles without start -> out_valid stays 0.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Left-shifting register with LSB insert; serial bits enter at bit 0 and
// migrate toward the MSB, so the first bit of a word ends up as its MSB.
module sipo_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over shifting so a frame restart drops the partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects WIDTH serial bits into a word and presents it
// through a one-deep output buffer, flagging dropped words as a sticky overrun.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     bit_valid,
    input  logic                     serial_in,
    input  logic                     cont,
    input  logic                     out_ready,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             clr;
    logic             shift_en;
    logic             complete;
    logic             load;
    logic             drop;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .shift_en (shift_en),
        .serial_in(serial_in),
        .q        (shreg)
    );

    // The completing bit is not in the shifter yet, so build the word from
    // the shifter contents plus the incoming bit.
    assign word = {shreg[WIDTH-2:0], serial_in};

    // A word is accepted into the buffer when it is empty or being drained
    // in the same cycle; otherwise it is lost.
    assign load = complete && (!out_valid || out_ready);
    assign drop = complete && out_valid && !out_ready;

    assign busy    = (state_q == SHIFT);
    assign bit_cnt = cnt_q;

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; start always wins over a coincident bit_valid.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr      = 1'b0;
        shift_en = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    clr     = 1'b1;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    clr   = 1'b1;
                    cnt_d = '0;
                end else if (bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        if (!cont) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-deep output buffer with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= word;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_err) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed testbench for sipo_frame_ctrl at WIDTH = 8.
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       bit_valid;
    logic       serial_in;
    logic       cont;
    logic       out_ready;
    logic       clear_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic [2:0] bit_cnt;
    logic       overrun;

    int n_cmp;
    int n_err;

    sipo_frame_ctrl #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bit_valid(bit_valid),
        .serial_in(serial_in),
        .cont     (cont),
        .out_ready(out_ready),
        .clear_err(clear_err),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .bit_cnt  (bit_cnt),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, pass one rising edge, return at the next negedge.
    task automatic step(input logic s, input logic bv, input logic sin);
        start     = s;
        bit_valid = bv;
        serial_in = sin;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i]);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        serial_in = 1'b0;
        cont      = 1'b0;
        out_ready = 1'b1;
        clear_err = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Reset state
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cnt", bit_cnt, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_data", out_data, 0);

        // bit_valid in IDLE without start is ignored
        step(1'b0, 1'b1, 1'b1);
        check_eq("idle_ign_busy", busy, 0);
        check_eq("idle_ign_cnt", bit_cnt, 0);

        // Basic frame 0xB2; bit_valid together with start is ignored
        step(1'b1, 1'b1, 1'b1);
        check_eq("basic_busy", busy, 1);
        check_eq("basic_cnt0", bit_cnt, 0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_eq("basic_cnt4", bit_cnt, 4);
        check_eq("basic_nv", out_valid, 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("basic_valid", out_valid, 1);
        check_eq("basic_data", out_data, 8'hB2);
        check_eq("basic_idle", busy, 0);
        check_eq("basic_cnt_wrap", bit_cnt, 0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("basic_consumed", out_valid, 0);
        check_eq("basic_hold_data", out_data, 8'hB2);

        // Gapped bits
        step(1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hB2;
            step(1'b0, 1'b1, w[i]);
            if (i != 0) begin
                step(1'b0, 1'b0, 1'b1);
                check_eq($sformatf("gap_cnt%0d", 8 - i), bit_cnt, 8 - i);
            end
        end
        check_eq("gap_valid", out_valid, 1);
        check_eq("gap_data", out_data, 8'hB2);
        step(1'b0, 1'b0, 1'b0);

        // Backpressure and overrun in continuous framing
        cont      = 1'b1;
        out_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        send_word(8'hB2);
        check_eq("bp_valid1", out_valid, 1);
        check_eq("bp_data1", out_data, 8'hB2);
        check_eq("bp_busy", busy, 1);
        check_eq("bp_ovr0", overrun, 0);
        send_word(8'h5A);
        check_eq("bp_hold", out_data, 8'hB2);
        check_eq("bp_ovr1", overrun, 1);
        check_eq("bp_valid2", out_valid, 1);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_eq("bp_drain", out_valid, 0);
        check_eq("bp_ovr_sticky", overrun, 1);
        out_ready = 1'b0;
        clear_err = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clear_err = 1'b0;
        check_eq("bp_clear", overrun, 0);
        check_eq("bp_still_shift", busy, 1);

        // Back-to-back accept in the completion cycle
        send_word(8'hB2);
        check_eq("b2b_valid1", out_valid, 1);
        for (int i = 7; i >= 1; i--) begin
            logic [7:0] w;
            w = 8'h5A;
            step(1'b0, 1'b1, w[i]);
        end
        out_ready = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        check_eq("b2b_valid2", out_valid, 1);
        check_eq("b2b_data", out_data, 8'h5A);
        check_eq("b2b_ovr", overrun, 0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("b2b_held", out_data, 8'h5A);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_eq("b2b_drain", out_valid, 0);

        // Restart discards partial word; coincident bit_valid ignored
        cont = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1);
        end
        check_eq("rs_cnt5", bit_cnt, 5);
        step(1'b1, 1'b1, 1'b1);
        check_eq("rs_cnt0", bit_cnt, 0);
        check_eq("rs_busy", busy, 1);
        send_word(8'h3C);
        check_eq("rs_valid", out_valid, 1);
        check_eq("rs_data", out_data, 8'h3C);
        check_eq("rs_idle", busy, 0);
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-word with a held word in the buffer
        out_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        send_word(8'hA5);
        check_eq("rm_held", out_data, 8'hA5);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
        end
        check_eq("rm_cnt4", bit_cnt, 4);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        check_eq("rm_valid", out_valid, 0);
        check_eq("rm_data", out_data, 0);
        check_eq("rm_busy", busy, 0);
        check_eq("rm_cnt", bit_cnt, 0);
        check_eq("rm_ovr", overrun, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check_eq($sformatf("rm_nowrd%0d", i), {busy, out_valid}, 0);
        end
        check_eq("rm_cnt_end", bit_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
